// File: rtl/pipeline_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding imem requests and
// drives the fetch->decode latch, with halt buffering and branch/jump redirect flush.
module pipeline_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_q, hold_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_instr_q, out_instr_d;

    logic        deliver;
    logic [31:0] deliver_word;
    logic [31:0] target;

    assign target = {redirect_pc[31:2], 2'b00};

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_d       = hold_q;
        deliver      = 1'b0;
        deliver_word = hold_q;
        case (state_q)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_d = target;
                    if (imem_gnt) state_d = S_FLUSH;
                end else if (imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (redirect_valid) begin
                        pc_d    = target;
                        state_d = S_REQ;
                    end else if (fetch_en) begin
                        deliver      = 1'b1;
                        deliver_word = imem_rdata;
                        pc_d         = pc_q + 32'd4;
                        state_d      = S_REQ;
                    end else begin
                        hold_d  = imem_rdata;
                        state_d = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    // Response still owed by memory: wait it out and discard it.
                    pc_d    = target;
                    state_d = S_FLUSH;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    hold_d  = '0;
                    pc_d    = target;
                    state_d = S_REQ;
                end else if (fetch_en) begin
                    deliver      = 1'b1;
                    deliver_word = hold_q;
                    pc_d         = pc_q + 32'd4;
                    state_d      = S_REQ;
                end
            end
            S_FLUSH: begin
                if (redirect_valid) pc_d = target;
                if (imem_rvalid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    // Redirect kills the latch even while halted; a halt otherwise freezes it.
    always_comb begin
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;
        if (redirect_valid) begin
            out_valid_d = 1'b0;
        end else if (fetch_en) begin
            if (deliver) begin
                out_valid_d = 1'b1;
                out_pc_d    = pc_q;
                out_instr_d = deliver_word;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_REQ;
            pc_q        <= {RESET_PC[31:2], 2'b00};
            hold_q      <= '0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_instr_q <= NOP_INSTR;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            hold_q      <= hold_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
        end
    end

    assign imem_req  = (state_q == S_REQ);
    assign imem_addr = pc_q;
    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_instr = out_instr_q;

endmodule

// File: tb/tb_pipeline_fetch_unit.sv
// Bench for pipeline_fetch_unit: hand-derived vector table, directed corner sequences,
// and randomized memory/halt/redirect traffic against a transaction-level model.
module tb_pipeline_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    always #5 clk = ~clk;

    pipeline_fetch_unit #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr)
    );

    int checks = 0;
    int errors = 0;

    // Transaction-level model: flags describing what the fetcher is waiting on.
    bit          m_req, m_inflight, m_stale, m_held, m_ov;
    logic [31:0] m_pc, m_hw, m_opc, m_oi;
    int          pend;

    typedef struct {
        bit          fe;
        bit          g;
        bit          rvl;
        logic [31:0] rd;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_ov;
        logic [31:0] e_opc;
        logic [31:0] e_oi;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input bit fe, input bit g, input bit rvl, input logic [31:0] rd,
                                input bit e_req, input logic [31:0] e_addr, input bit e_ov,
                                input logic [31:0] e_opc, input logic [31:0] e_oi);
        vec_t v;
        v.fe = fe; v.g = g; v.rvl = rvl; v.rd = rd;
        v.e_req = e_req; v.e_addr = e_addr; v.e_ov = e_ov; v.e_opc = e_opc; v.e_oi = e_oi;
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_req = 1'b1; m_inflight = 1'b0; m_stale = 1'b0; m_held = 1'b0;
        m_pc = RPC; m_hw = '0; m_ov = 1'b0; m_opc = '0; m_oi = NOP;
        pend = -1;
    endtask

    task automatic model_step(input bit fe, input bit rv, input logic [31:0] tgt,
                              input bit g, input bit rvl, input logic [31:0] rd);
        logic [31:0] t;
        bit          dlv;
        logic [31:0] dw;
        t = {tgt[31:2], 2'b00};
        dlv = 1'b0;
        dw = '0;
        if (m_req) begin
            if (rv) m_pc = t;
            if (g) begin m_req = 1'b0; m_inflight = 1'b1; m_stale = rv; end
        end else if (m_inflight) begin
            if (rvl) begin
                m_inflight = 1'b0;
                if (m_stale || rv) begin
                    m_stale = 1'b0; m_req = 1'b1;
                    if (rv) m_pc = t;
                end else if (fe) begin
                    dlv = 1'b1; dw = rd;
                end else begin
                    m_held = 1'b1; m_hw = rd;
                end
            end else if (rv) begin
                m_pc = t; m_stale = 1'b1;
            end
        end else if (m_held) begin
            if (rv) begin m_held = 1'b0; m_req = 1'b1; m_pc = t; end
            else if (fe) begin m_held = 1'b0; dlv = 1'b1; dw = m_hw; end
        end
        if (rv) m_ov = 1'b0;
        else if (fe) begin
            if (dlv) begin
                m_ov = 1'b1; m_opc = m_pc; m_oi = dw;
                m_pc = m_pc + 32'd4; m_req = 1'b1;
            end else begin
                m_ov = 1'b0;
            end
        end
    endtask

    task automatic drive(input bit fe, input bit rv, input logic [31:0] tgt,
                         input bit g, input bit rvl, input logic [31:0] rd);
        fetch_en = fe; redirect_valid = rv; redirect_pc = tgt;
        imem_gnt = g; imem_rvalid = rvl; imem_rdata = rd;
    endtask

    // One clock: drive at the falling edge, check against the model, advance.
    task automatic cycle(input bit fe, input bit rv, input logic [31:0] tgt,
                         input bit g, input bit rvl, input logic [31:0] rd);
        drive(fe, rv, tgt, g, rvl, rd);
        #1;
        check32("imem_req", {31'b0, imem_req}, {31'b0, m_req});
        check32("imem_addr", imem_addr, m_pc);
        check32("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
        check32("out_pc", out_pc, m_opc);
        check32("out_instr", out_instr, m_oi);
        model_step(fe, rv, tgt, g, rvl, rd);
        @(negedge clk);
    endtask

    initial begin
        bit          g, rvl, fe, rv;
        logic [31:0] rd, tgt;

        tbl[0]  = mk(1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h00, 1'b0, 32'h00, NOP);
        tbl[1]  = mk(1'b1, 1'b0, 1'b1, 32'h00500093, 1'b0, 32'h00, 1'b0, 32'h00, NOP);
        tbl[2]  = mk(1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h04, 1'b1, 32'h00, 32'h00500093);
        tbl[3]  = mk(1'b1, 1'b0, 1'b1, 32'h00108113, 1'b0, 32'h04, 1'b0, 32'h00, 32'h00500093);
        tbl[4]  = mk(1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h08, 1'b1, 32'h04, 32'h00108113);
        tbl[5]  = mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h08, 1'b0, 32'h04, 32'h00108113);
        tbl[6]  = mk(1'b1, 1'b0, 1'b1, 32'h00000013, 1'b0, 32'h08, 1'b0, 32'h04, 32'h00108113);
        tbl[7]  = mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0C, 1'b1, 32'h08, 32'h00000013);
        tbl[8]  = mk(1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0C, 1'b0, 32'h08, 32'h00000013);
        tbl[9]  = mk(1'b1, 1'b0, 1'b1, 32'h00A00113, 1'b0, 32'h0C, 1'b0, 32'h08, 32'h00000013);
        tbl[10] = mk(1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h10, 1'b1, 32'h0C, 32'h00A00113);
        tbl[11] = mk(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h10, 1'b0, 32'h0C, 32'h00A00113);
        tbl[12] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h10, 1'b0, 32'h0C, 32'h00A00113);
        tbl[13] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h10, 1'b0, 32'h0C, 32'h00A00113);
        tbl[14] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h10, 1'b0, 32'h0C, 32'h00A00113);
        tbl[15] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h10, 1'b0, 32'h0C, 32'h00A00113);
        tbl[16] = mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h10, 1'b0, 32'h0C, 32'h00A00113);
        tbl[17] = mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h14, 1'b1, 32'h10, 32'hDEADBEEF);

        model_reset();
        @(negedge clk);
        #1;
        check32("rst_req", {31'b0, imem_req}, 32'd1);
        check32("rst_addr", imem_addr, RPC);
        check32("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check32("rst_out_pc", out_pc, 32'h0);
        check32("rst_out_instr", out_instr, NOP);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].fe, 1'b0, 32'h0, tbl[i].g, tbl[i].rvl, tbl[i].rd);
            #1;
            check32($sformatf("tbl%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].e_req});
            check32($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].e_addr);
            check32($sformatf("tbl%0d_out_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].e_ov});
            check32($sformatf("tbl%0d_out_pc", i), out_pc, tbl[i].e_opc);
            check32($sformatf("tbl%0d_out_instr", i), out_instr, tbl[i].e_oi);
            model_step(tbl[i].fe, 1'b0, 32'h0, tbl[i].g, tbl[i].rvl, tbl[i].rd);
            @(negedge clk);
        end

        // Redirect while waiting; the late response must be dropped.
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h203, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h11111111);
        check32("redir_wait_addr", imem_addr, 32'h200);
        check32("redir_wait_req", {31'b0, imem_req}, 32'd1);
        check32("redir_wait_valid", {31'b0, out_valid}, 32'd0);

        // Redirect coincident with a deliverable response.
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h40, 1'b0, 1'b1, 32'h22222222);
        check32("redir_rv_addr", imem_addr, 32'h40);
        check32("redir_rv_valid", {31'b0, out_valid}, 32'd0);

        // PC wrap at the top of the address space.
        cycle(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0);
        check32("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h33333333);
        check32("wrap_addr1", imem_addr, 32'h0);
        check32("wrap_out_pc", out_pc, 32'hFFFF_FFFC);
        check32("wrap_out_instr", out_instr, 32'h33333333);

        // Asynchronous reset mid-cycle while a response is owed.
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check32("arst_req", {31'b0, imem_req}, 32'd1);
        check32("arst_addr", imem_addr, RPC);
        check32("arst_out_valid", {31'b0, out_valid}, 32'd0);
        check32("arst_out_pc", out_pc, 32'h0);
        check32("arst_out_instr", out_instr, NOP);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h44444444);
        check32("stale_req", {31'b0, imem_req}, 32'd1);
        check32("stale_addr", imem_addr, RPC);
        check32("stale_out_valid", {31'b0, out_valid}, 32'd0);

        // Randomized traffic with a memory responder of 1..3 cycle latency.
        for (int n = 0; n < 3000; n++) begin
            fe  = ($urandom_range(0, 4) != 0);
            rv  = ($urandom_range(0, 9) == 0);
            tgt = $urandom;
            rd  = $urandom;
            rvl = 1'b0;
            if (pend == 0) begin
                rvl = 1'b1; pend = -1;
            end else if (pend > 0) begin
                pend--;
            end else if (!m_inflight && $urandom_range(0, 15) == 0) begin
                rvl = 1'b1;
            end
            g = m_req && ($urandom_range(0, 2) != 0);
            if (g) pend = $urandom_range(0, 2);
            cycle(fe, rv, tgt, g, rvl, rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
